pool_conv_pingpong_buffer: RTL and testbench

- Double-banked IFM buffer placed between the pooling stage and the next convolution stage.
- The pool side writes one whole output volume (IFM_DEPTH maps of IFM_SIZE x IFM_SIZE) into the free bank. The conv side reads the other bank through two read ports.
- Bank ownership is tracked with start/end handshakes, so pool and conv overlap on alternate layers' data without corrupting each other.

---
 rtl/pool_conv_pingpong_buffer_pkg.sv | 25 ++
 rtl/pool_conv_pingpong_buffer_bank_ram.sv | 52 +++++
 rtl/pool_conv_pingpong_buffer.sv | 135 +++++++++++++
 tb/tb_pool_conv_pingpong_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pool_conv_pingpong_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_conv_pingpong_buffer_pkg
// Shared types, geometry defaults and index helper for the ping-pong IFM buffer.
// Revision: 1.0
// ---------------------------------------------------------------------------
package pool_conv_pingpong_buffer_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        READING = 1'b1
    } reader_state_t;

    localparam int unsigned DEF_IFM_SIZE  = 5;
    localparam int unsigned DEF_IFM_DEPTH = 16;
    localparam int unsigned IFM_AREA      = DEF_IFM_SIZE * DEF_IFM_SIZE;

    function automatic int unsigned map_index(input int unsigned sel,
                                              input int unsigned addr,
                                              input int unsigned area);
        return sel * area + addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_conv_pingpong_buffer_bank_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_conv_pingpong_buffer_bank_ram
// 1-write / 2-read synchronous RAM; the bank bit is the MSB of every index.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pool_conv_pingpong_buffer_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int LIN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic                  wr_bank,
    input  logic [LIN_WIDTH-1:0]  wr_index,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_bank,
    input  logic                  rd_enable_a,
    input  logic                  rd_valid_a,
    input  logic [LIN_WIDTH-1:0]  rd_index_a,
    input  logic                  rd_enable_b,
    input  logic                  rd_valid_b,
    input  logic [LIN_WIDTH-1:0]  rd_index_b,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic [DATA_WIDTH-1:0] data_out_b
);

    logic [DATA_WIDTH-1:0] mem [0:(2**(LIN_WIDTH+1))-1];

    always_ff @(posedge clk) begin
        if (wr_enable) begin
            mem[{wr_bank, wr_index}] <= wr_data;
        end
    end

    // Out-of-range reads still update the port, but with zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_a <= '0;
            data_out_b <= '0;
        end else begin
            if (rd_enable_a) begin
                data_out_a <= rd_valid_a ? mem[{rd_bank, rd_index_a}] : '0;
            end
            if (rd_enable_b) begin
                data_out_b <= rd_valid_b ? mem[{rd_bank, rd_index_b}] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pool_conv_pingpong_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_conv_pingpong_buffer
// Two-bank IFM buffer between pooling (writer) and convolution (reader).
// Revision: 1.0
// ---------------------------------------------------------------------------
module pool_conv_pingpong_buffer
    import pool_conv_pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int IFM_SIZE     = DEF_IFM_SIZE,
    parameter int IFM_DEPTH    = DEF_IFM_DEPTH,
    parameter int ADDRESS_SIZE = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int SEL_WIDTH    = $clog2(IFM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_enable,
    input  logic [ADDRESS_SIZE-1:0] wr_address,
    input  logic [SEL_WIDTH-1:0]    wr_sel,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_done,
    output logic                    buffer_ready,
    output logic                    start_to_next,
    input  logic                    end_from_next,
    input  logic                    rd_enable_A,
    input  logic                    rd_enable_B,
    input  logic [ADDRESS_SIZE-1:0] rd_address_A,
    input  logic [ADDRESS_SIZE-1:0] rd_address_B,
    input  logic [SEL_WIDTH-1:0]    rd_sel,
    output logic [DATA_WIDTH-1:0]   data_out_A,
    output logic [DATA_WIDTH-1:0]   data_out_B,
    output logic                    overflow
);

    localparam int unsigned AREA      = IFM_SIZE * IFM_SIZE;
    localparam int          LIN_WIDTH = $clog2(IFM_DEPTH * IFM_SIZE * IFM_SIZE);

    reader_state_t  state, state_next;
    logic           wb, rb;
    logic [1:0]     full_count, full_count_next;
    logic           launch, launch_next;
    logic           rd_release, wr_accept;
    logic           wr_in_range, rd_sel_ok, rd_ok_a, rd_ok_b;
    logic [LIN_WIDTH-1:0] wr_index, rd_index_a, rd_index_b;

    assign buffer_ready = (full_count < 2'd2);
    assign rd_release   = (state == READING) && end_from_next;
    // A full buffer still takes a new layer when the reader frees a bank this cycle.
    assign wr_accept    = wr_done && ((full_count != 2'd2) || rd_release);

    assign wr_in_range = ({1'b0, wr_address} < (ADDRESS_SIZE+1)'(AREA)) &&
                         ({1'b0, wr_sel} < (SEL_WIDTH+1)'(IFM_DEPTH));
    assign rd_sel_ok   = ({1'b0, rd_sel} < (SEL_WIDTH+1)'(IFM_DEPTH));
    assign rd_ok_a     = rd_sel_ok && ({1'b0, rd_address_A} < (ADDRESS_SIZE+1)'(AREA));
    assign rd_ok_b     = rd_sel_ok && ({1'b0, rd_address_B} < (ADDRESS_SIZE+1)'(AREA));

    assign wr_index   = LIN_WIDTH'(map_index(32'(wr_sel), 32'(wr_address), AREA));
    assign rd_index_a = LIN_WIDTH'(map_index(32'(rd_sel), 32'(rd_address_A), AREA));
    assign rd_index_b = LIN_WIDTH'(map_index(32'(rd_sel), 32'(rd_address_B), AREA));

    always_comb begin
        state_next      = state;
        launch_next     = 1'b0;
        full_count_next = full_count;
        if (wr_accept && !rd_release) begin
            full_count_next = full_count + 2'd1;
        end else if (!wr_accept && rd_release) begin
            full_count_next = full_count - 2'd1;
        end
        case (state)
            IDLE: begin
                if (full_count != 2'd0) begin
                    launch_next = 1'b1;
                    state_next  = READING;
                end
            end
            READING: begin
                if (end_from_next) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wb            <= 1'b0;
            rb            <= 1'b0;
            full_count    <= 2'd0;
            launch        <= 1'b0;
            start_to_next <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_next;
            full_count    <= full_count_next;
            launch        <= launch_next;
            start_to_next <= launch;
            if (wr_accept) begin
                wb <= ~wb;
            end
            if (rd_release) begin
                rb <= ~rb;
            end
            if (wr_done && !wr_accept) begin
                overflow <= 1'b1;
            end
        end
    end

    pool_conv_pingpong_buffer_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .LIN_WIDTH  (LIN_WIDTH)
    ) u_bank_ram (
        .clk         (clk),
        .reset       (reset),
        .wr_enable   (wr_enable && buffer_ready && wr_in_range),
        .wr_bank     (wb),
        .wr_index    (wr_index),
        .wr_data     (wr_data),
        .rd_bank     (rb),
        .rd_enable_a (rd_enable_A),
        .rd_valid_a  (rd_ok_a),
        .rd_index_a  (rd_index_a),
        .rd_enable_b (rd_enable_B),
        .rd_valid_b  (rd_ok_b),
        .rd_index_b  (rd_index_b),
        .data_out_a  (data_out_A),
        .data_out_b  (data_out_B)
    );

endmodule
`default_nettype wire

// File: tb/tb_pool_conv_pingpong_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pool_conv_pingpong_buffer
// Directed stimulus with queued expectations checked by a per-edge monitor.
// ---------------------------------------------------------------------------
module tb_pool_conv_pingpong_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_enable, wr_done, end_from_next;
    logic [4:0]  wr_address, rd_address_A, rd_address_B;
    logic [3:0]  wr_sel, rd_sel;
    logic [31:0] wr_data;
    logic        rd_enable_A, rd_enable_B;
    logic        buffer_ready, start_to_next, overflow;
    logic [31:0] data_out_A, data_out_B;

    always #5 clk = ~clk;

    pool_conv_pingpong_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .wr_enable     (wr_enable),
        .wr_address    (wr_address),
        .wr_sel        (wr_sel),
        .wr_data       (wr_data),
        .wr_done       (wr_done),
        .buffer_ready  (buffer_ready),
        .start_to_next (start_to_next),
        .end_from_next (end_from_next),
        .rd_enable_A   (rd_enable_A),
        .rd_enable_B   (rd_enable_B),
        .rd_address_A  (rd_address_A),
        .rd_address_B  (rd_address_B),
        .rd_sel        (rd_sel),
        .data_out_A    (data_out_A),
        .data_out_B    (data_out_B),
        .overflow      (overflow)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int          q_start[$];
    logic        mon_fa, mon_fb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (edge %0d)", name, cyc);
    endtask

    // Monitor: reads issued before an edge are compared just after it.
    always @(posedge clk) begin
        cyc++;
        mon_fa = rd_enable_A;
        mon_fb = rd_enable_B;
        #1;
        if (mon_fa) begin
            if (q_a.size() == 0) flag("read_A without expectation");
            else check("read_A", data_out_A, q_a.pop_front());
        end
        if (mon_fb) begin
            if (q_b.size() == 0) flag("read_B without expectation");
            else check("read_B", data_out_B, q_b.pop_front());
        end
        if (start_to_next) begin
            if (q_start.size() == 0) flag("unexpected start_to_next");
            else check("start_to_next edge", 32'(cyc), 32'(q_start.pop_front()));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [3:0] sel, input logic [4:0] addr, input logic [31:0] d);
        wr_enable  = 1'b1;
        wr_sel     = sel;
        wr_address = addr;
        wr_data    = d;
        @(negedge clk);
        wr_enable  = 1'b0;
    endtask

    task automatic pulse(input bit done, input bit fin, input bit expect_start);
        wr_done       = done;
        end_from_next = fin;
        if (expect_start) q_start.push_back(cyc + 3);
        @(negedge clk);
        wr_done       = 1'b0;
        end_from_next = 1'b0;
    endtask

    task automatic read_pair(input logic [3:0] sel,
                             input logic [4:0] aa, input bit ea, input logic [31:0] xa,
                             input logic [4:0] ab, input bit eb, input logic [31:0] xb);
        rd_sel       = sel;
        rd_address_A = aa;
        rd_address_B = ab;
        rd_enable_A  = ea;
        rd_enable_B  = eb;
        if (ea) q_a.push_back(xa);
        if (eb) q_b.push_back(xb);
        @(negedge clk);
        rd_enable_A  = 1'b0;
        rd_enable_B  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr_enable = 0; wr_done = 0; end_from_next = 0;
        wr_address = 0; wr_sel = 0; wr_data = 0;
        rd_enable_A = 0; rd_enable_B = 0;
        rd_address_A = 0; rd_address_B = 0; rd_sel = 0;
        #3 reset = 1'b0;
        #9;
        check("reset start_to_next", {31'd0, start_to_next}, 32'd0);
        check("reset data_out_A", data_out_A, 32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);
        check("reset buffer_ready", {31'd0, buffer_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        wait_cycles(1);

        // Single word round trip through bank 0
        write_word(4'd3, 5'd7, 32'hDEADBEEF);
        pulse(1, 0, 1);
        wait_cycles(3);
        check("buffer_ready one full", {31'd0, buffer_ready}, 32'd1);
        read_pair(4'd3, 5'd7, 1, 32'hDEADBEEF, 5'd0, 0, 32'd0);
        pulse(0, 1, 0);
        wait_cycles(2);

        // Out-of-range write (would alias sel1/addr0) and read
        write_word(4'd1, 5'd0, 32'h11111111);
        write_word(4'd0, 5'd25, 32'h0BAD0BAD);
        pulse(1, 0, 1);
        wait_cycles(3);
        read_pair(4'd1, 5'd0, 1, 32'h11111111, 5'd0, 1, 32'h11111111);
        read_pair(4'd1, 5'd0, 1, 32'h11111111, 5'd25, 1, 32'd0);
        pulse(0, 1, 0);
        wait_cycles(2);

        // Two layers back to back, then overflow and a dropped write
        write_word(4'd0, 5'd0, 32'h1);
        write_word(4'd0, 5'd1, 32'hA1);
        pulse(1, 0, 1);
        write_word(4'd0, 5'd0, 32'h2);
        pulse(1, 0, 0);
        wait_cycles(1);
        check("buffer_ready both full", {31'd0, buffer_ready}, 32'd0);
        check("overflow before third done", {31'd0, overflow}, 32'd0);
        pulse(1, 0, 0);
        check("overflow after third done", {31'd0, overflow}, 32'd1);
        write_word(4'd0, 5'd1, 32'h99);
        wait_cycles(2);
        read_pair(4'd0, 5'd0, 1, 32'h1, 5'd1, 1, 32'hA1);
        pulse(0, 1, 1);
        wait_cycles(3);
        check("buffer_ready after drain", {31'd0, buffer_ready}, 32'd1);
        read_pair(4'd0, 5'd0, 1, 32'h2, 5'd0, 0, 32'd0);

        // Simultaneous end_from_next and wr_done with one full bank
        write_word(4'd0, 5'd0, 32'h3);
        pulse(1, 1, 1);
        wait_cycles(3);
        check("buffer_ready after swap", {31'd0, buffer_ready}, 32'd1);
        read_pair(4'd0, 5'd0, 1, 32'h3, 5'd1, 1, 32'hA1);

        // Fill the free bank completely and read it back on both ports
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 25; a++)
                write_word(4'(s), 5'(a), 32'(s * 256 + a));
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        wait_cycles(3);
        for (int s = 0; s < 16; s++)
            for (int k = 0; k < 13; k++)
                read_pair(4'(s), 5'(2 * k), 1, 32'(s * 256 + 2 * k),
                          5'(2 * k + 1), (2 * k + 1) < 25, 32'(s * 256 + 2 * k + 1));

        // Async reset right after a start_to_next with both banks full
        write_word(4'd2, 5'd2, 32'h22);
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        pulse(1, 0, 0);
        @(negedge clk);
        check("start_to_next before reset", {31'd0, start_to_next}, 32'd1);
        check("buffer_ready before reset", {31'd0, buffer_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("async reset start_to_next", {31'd0, start_to_next}, 32'd0);
        check("async reset data_out_A", data_out_A, 32'd0);
        check("async reset data_out_B", data_out_B, 32'd0);
        check("async reset overflow", {31'd0, overflow}, 32'd0);
        check("async reset buffer_ready", {31'd0, buffer_ready}, 32'd1);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(6);
        write_word(4'd4, 5'd4, 32'h44);
        pulse(1, 0, 1);
        wait_cycles(3);
        read_pair(4'd4, 5'd4, 1, 32'h44, 5'd4, 1, 32'h44);
        wait_cycles(2);

        if (q_a.size() != 0) flag("read_A expectations left over");
        if (q_b.size() != 0) flag("read_B expectations left over");
        if (q_start.size() != 0) flag("expected start_to_next never seen");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
